// File: rtl/piso_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_byte_serializer
//  Description : Parallel-in / serial-out transmitter. Accepts a word over a
//                valid/ready handshake, drives it one bit per clock on `so`
//                together with a held shift-direction bit `dir`, and can
//                insert a fixed idle gap after each word.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_byte_serializer #(
   parameter int   WIDTH    = 8,     // word width, 2..16
   parameter int   GAP      = 0,     // idle cycles after each word, 0..15
   parameter logic IDLE_BIT = 1'b0   // level on `so` when no data bit is sent
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             msb_first,
   output logic             so,
   output logic             dir,
   output logic             busy,
   output logic             done
);

   // Bit counter holds "bits remaining after the one currently on so".
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Gap counter covers up to 15 idle cycles.
   localparam int GAP_W = 4;
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

   // Without a gap the last data cycle may also take the next word.
   localparam bit NO_GAP = (GAP == 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t             state, state_d;
   logic [WIDTH-1:0]   sreg, sreg_d, sreg_shifted;
   logic [CNT_W-1:0]   bitcnt, bitcnt_d;
   logic [GAP_W-1:0]   gapcnt, gapcnt_d;
   logic               dir_d;
   logic               so_d;
   logic               busy_d;
   logic               done_d;
   logic               last_bit;
   logic               accept;

   // Handshake decode: ready in IDLE, and in the last data cycle when no gap follows.
   always_comb begin
      last_bit  = (state == S_SHIFT) && (bitcnt == '0);
      din_ready = (state == S_IDLE) || (NO_GAP && last_bit);
      accept    = din_valid && din_ready;
   end

   // Shift toward whichever end currently feeds `so`.
   always_comb begin
      sreg_shifted = dir ? (sreg << 1) : (sreg >> 1);
   end

   // Next-state and next-output decode for the serializer.
   always_comb begin
      state_d  = state;
      sreg_d   = sreg;
      bitcnt_d = bitcnt;
      gapcnt_d = gapcnt;
      dir_d    = dir;
      so_d     = IDLE_BIT;

      case (state)
         S_IDLE: begin
            state_d = S_IDLE;
         end

         S_SHIFT: begin
            if (bitcnt != '0) begin
               // More bits to go: present the next one.
               sreg_d   = sreg_shifted;
               bitcnt_d = bitcnt - CNT_ONE;
               so_d     = dir ? sreg_shifted[WIDTH-1] : sreg_shifted[0];
               state_d  = S_SHIFT;
            end else if (GAP > 0) begin
               state_d  = S_GAP;
               gapcnt_d = GAP_LOAD;
            end else begin
               state_d  = S_IDLE;
            end
         end

         S_GAP: begin
            if (gapcnt == '0) begin
               state_d = S_IDLE;
            end else begin
               gapcnt_d = gapcnt - GAP_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new word overrides whatever the current state planned; this only
      // happens from IDLE or from the final data cycle.
      if (accept) begin
         state_d  = S_SHIFT;
         sreg_d   = din;
         bitcnt_d = CNT_LOAD;
         dir_d    = msb_first;
         so_d     = msb_first ? din[WIDTH-1] : din[0];
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_SHIFT) && (bitcnt_d == '0);
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Datapath and registered outputs; reset abandons any word in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg   <= '0;
         bitcnt <= '0;
         gapcnt <= '0;
         dir    <= 1'b0;
         so     <= IDLE_BIT;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         sreg   <= sreg_d;
         bitcnt <= bitcnt_d;
         gapcnt <= gapcnt_d;
         dir    <= dir_d;
         so     <= so_d;
         busy   <= busy_d;
         done   <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_piso_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_byte_serializer
//  Description : Self-checking bench for piso_byte_serializer. One instance
//                without a gap and one with a 4-cycle gap, both checked
//                against a bit-order model of the serial stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_byte_serializer;

   localparam int W = 8;
   localparam int G = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;

   logic [W-1:0] din0 = '0;
   logic         v0 = 1'b0, m0 = 1'b0;
   logic         rdy0, so0, dir0, busy0, done0;

   logic [W-1:0] din4 = '0;
   logic         v4 = 1'b0, m4 = 1'b0;
   logic         rdy4, so4, dir4, busy4, done4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   piso_byte_serializer #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
      .msb_first(m0), .so(so0), .dir(dir0), .busy(busy0), .done(done0)
   );

   piso_byte_serializer #(.WIDTH(W), .GAP(G), .IDLE_BIT(1'b0)) dut4 (
      .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .din_ready(rdy4),
      .msb_first(m4), .so(so4), .dir(dir4), .busy(busy4), .done(done4)
   );

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: k-th transmitted bit of a word in the requested order.
   function automatic logic ref_bit(input logic [W-1:0] word, input logic msb, input int k);
      return msb ? word[W-1-k] : word[k];
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_cmp++;
      if ({so0, dir0, busy0, done0, rdy0} !== 5'b00001) begin
         n_bad++;
         $display("FAIL reset_gap0: so/dir/busy/done/ready got %b want 00001", {so0, dir0, busy0, done0, rdy0});
      end
      n_cmp++;
      if ({so4, dir4, busy4, done4, rdy4} !== 5'b00001) begin
         n_bad++;
         $display("FAIL reset_gap4: so/dir/busy/done/ready got %b want 00001", {so4, dir4, busy4, done4, rdy4});
      end
   endtask

   // Send one isolated word on the no-gap instance and check every bit cycle.
   task automatic send_check0(input logic [W-1:0] word, input logic msb, input string tag);
      logic [3:0] exp;
      n_cmp++;
      if (rdy0 !== 1'b1) begin
         n_bad++;
         $display("FAIL %s ready_before_accept: got %b want 1", tag, rdy0);
      end
      din0 = word;
      m0   = msb;
      v0   = 1'b1;
      step();
      v0   = 1'b0;
      din0 = W'($urandom);
      m0   = 1'($urandom);
      for (int k = 0; k < W; k++) begin
         exp = {ref_bit(word, msb, k), msb, 1'b1, (k == W - 1)};
         n_cmp++;
         if ({so0, dir0, busy0, done0} !== exp) begin
            n_bad++;
            $display("FAIL %s bit%0d so/dir/busy/done: got %b want %b", tag, k, {so0, dir0, busy0, done0}, exp);
         end
         step();
      end
      n_cmp++;
      if ({so0, busy0, done0, rdy0, dir0} !== {4'b0001, msb}) begin
         n_bad++;
         $display("FAIL %s after_word so/busy/done/ready/dir: got %b want %b", tag, {so0, busy0, done0, rdy0, dir0}, {4'b0001, msb});
      end
   endtask

   task automatic test_lsb_first();
      send_check0(8'hB5, 1'b0, "lsb_B5");
   endtask

   task automatic test_msb_first();
      send_check0(8'hB5, 1'b1, "msb_B5");
   endtask

   task automatic test_random_words();
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 3)) step();
         send_check0(W'($urandom), 1'($urandom), "random_word");
      end
   endtask

   // Continuous stream on the no-gap instance: bits of all words back to back.
   task automatic test_back_to_back();
      logic [W-1:0] words[$];
      logic         msbs[$];
      int           idx, n, w, off;
      logic         acc;
      logic [4:0]   exp;
      words = '{8'hFF, 8'h00};
      msbs  = '{1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         words.push_back(W'($urandom));
         msbs.push_back(1'($urandom));
      end
      n = words.size();
      din0 = words[0];
      m0   = msbs[0];
      v0   = 1'b1;
      step();
      idx = 1;
      for (int t = 0; t < n * W; t++) begin
         w   = t / W;
         off = t % W;
         exp = {ref_bit(words[w], msbs[w], off), msbs[w], 1'b1, (off == W - 1), (off == W - 1)};
         n_cmp++;
         if ({so0, dir0, busy0, done0, rdy0} !== exp) begin
            n_bad++;
            $display("FAIL b2b cycle%0d so/dir/busy/done/ready: got %b want %b", t, {so0, dir0, busy0, done0, rdy0}, exp);
         end
         v0 = (idx < n);
         if (rdy0 && idx < n) begin
            din0 = words[idx];
            m0   = msbs[idx];
         end else begin
            din0 = W'($urandom);
            m0   = 1'($urandom);
         end
         acc = v0 && rdy0;
         step();
         if (acc) idx++;
      end
      v0 = 1'b0;
      n_cmp++;
      if ({so0, busy0, done0, rdy0} !== 4'b0001) begin
         n_bad++;
         $display("FAIL b2b end so/busy/done/ready: got %b want 0001", {so0, busy0, done0, rdy0});
      end
   endtask

   // Gap instance with din_valid held high: word, gap, one idle, next word.
   task automatic test_gap();
      localparam int P = W + G + 1;
      logic [W-1:0] words[$];
      logic         msbs[$];
      int           idx, n, w, off;
      logic         acc;
      logic [4:0]   exp;
      words = '{8'h81, 8'h81};
      msbs  = '{1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         words.push_back(W'($urandom));
         msbs.push_back(1'($urandom));
      end
      n = words.size();
      n_cmp++;
      if (rdy4 !== 1'b1) begin
         n_bad++;
         $display("FAIL gap ready_before_first: got %b want 1", rdy4);
      end
      din4 = words[0];
      m4   = msbs[0];
      v4   = 1'b1;
      step();
      idx = 1;
      for (int t = 0; t < n * P; t++) begin
         w   = t / P;
         off = t % P;
         exp = {(off < W) ? ref_bit(words[w], msbs[w], off) : 1'b0,
                msbs[w], (off < W + G), (off == W - 1), (off == W + G)};
         n_cmp++;
         if ({so4, dir4, busy4, done4, rdy4} !== exp) begin
            n_bad++;
            $display("FAIL gap cycle%0d so/dir/busy/done/ready: got %b want %b", t, {so4, dir4, busy4, done4, rdy4}, exp);
         end
         v4 = (idx < n);
         if (rdy4 && idx < n) begin
            din4 = words[idx];
            m4   = msbs[idx];
         end else begin
            din4 = W'($urandom);
            m4   = 1'($urandom);
         end
         acc = v4 && rdy4;
         step();
         if (acc) idx++;
      end
      v4 = 1'b0;
      n_cmp++;
      if ({so4, busy4, done4, rdy4} !== 4'b0001) begin
         n_bad++;
         $display("FAIL gap end so/busy/done/ready: got %b want 0001", {so4, busy4, done4, rdy4});
      end
   endtask

   // Reset after the third bit, with a handshake offered in the reset cycle.
   task automatic test_reset_mid_word();
      din0 = 8'hAA;
      m0   = 1'b1;
      v0   = 1'b1;
      step();
      v0   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (so0 !== ref_bit(8'hAA, 1'b1, k)) begin
            n_bad++;
            $display("FAIL midreset bit%0d so: got %b want %b", k, so0, ref_bit(8'hAA, 1'b1, k));
         end
         if (k < 2) step();
      end
      rst  = 1'b1;
      v0   = 1'b1;
      din0 = 8'h55;
      m0   = 1'b1;
      step();
      rst  = 1'b0;
      v0   = 1'b0;
      n_cmp++;
      if ({so0, dir0, busy0, done0, rdy0} !== 5'b00001) begin
         n_bad++;
         $display("FAIL midreset outputs so/dir/busy/done/ready: got %b want 00001", {so0, dir0, busy0, done0, rdy0});
      end
      step();
      n_cmp++;
      if ({so0, dir0, busy0, done0} !== 4'b0000) begin
         n_bad++;
         $display("FAIL midreset dropped_handshake so/dir/busy/done: got %b want 0000", {so0, dir0, busy0, done0});
      end
      send_check0(8'h0F, 1'b0, "after_reset_0F");
   endtask

   initial begin
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_random_words();
      test_back_to_back();
      test_gap();
      test_reset_mid_word();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piso_byte_serializer.md
# piso_byte_serializer

Parallel-in, serial-out transmitter that sits directly upstream of the 8-bit left/right shift register stage. It accepts a parallel word over a valid/ready handshake, then drives it one bit per clock onto the serial line feeding the shift register's serial input. Alongside each word it drives that word's shift-direction control. An optional idle gap of constant bits is inserted between words so the downstream register can be flushed.

## Interface
- WIDTH, 8, word width in bits; legal range 2..16.
- GAP, 0, idle cycles inserted after each word; legal range 0..15.
- IDLE_BIT, 1'b0, level driven on `so` when no data bit is being sent.

- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to send.
- din_valid  input  1  `din` and `msb_first` are valid.
- din_ready  output  1  the block can accept a word this cycle.
- msb_first  input  1  bit order for the word: 1 = MSB first, 0 = LSB first. Sampled together with `din`.
- so  output  1  serial data; connects to the shift register's serial input.
- dir  output  1  direction for the downstream register; connects to its `left_right` input.
- busy  output  1  a word or gap is in progress.
- done  output  1  one-cycle pulse while the last bit of a word is on `so`.

## Operation
- **FSM states:** IDLE, SHIFT, GAP.
- **IDLE:**
  - `din_ready`=1, `so`=IDLE_BIT, `busy`=0.
  - On `din_valid`&&`din_ready`, capture `din` into the shift register `sreg`, `msb_first` into `dir`, and load `bitcnt`=WIDTH-1. Go to SHIFT.
- **SHIFT:**
  - `so` = `sreg`[WIDTH-1] when `dir`=1, else `sreg`[0].
  - Each cycle, shift `sreg` toward the output end and decrement `bitcnt`.
  - When `bitcnt`==0 (last bit on `so`), assert `done`. Next state is GAP if GAP>0, else IDLE.
  - The next state is SHIFT again instead when GAP==0 and a new word is accepted this cycle.
- **Back-to-back transfers:**
  - With GAP==0, `din_ready` is also 1 during the last SHIFT cycle.
  - A word accepted in that cycle starts on the next cycle with no idle bit between words.
  - With GAP>0, `din_ready`=0 throughout SHIFT and GAP.
- **GAP:**
  - `so`=IDLE_BIT, `busy`=1.
  - `gapcnt` is loaded with GAP-1 on entry and counts down to 0, then the FSM returns to IDLE.
  - GAP state lasts exactly GAP cycles.
- **`dir` hold:** `dir` holds its captured value through SHIFT and GAP and until the next accept. Its reset value is 0.
- **Ignored inputs:** `din_valid` while `din_ready`=0 is ignored. `din` and `msb_first` are not sampled at that time.

## Timing
- **Reset** (sampled on a clk edge while `rst`=1):
  - State returns to IDLE and `bitcnt`=0, `gapcnt`=0.
  - Outputs after that edge: `so`=IDLE_BIT, `dir`=0, `busy`=0, `done`=0, `din_ready`=1.
- **Reset mid-word or mid-gap:** the word is abandoned, with no `done` pulse. The outputs take their reset values on the first edge where `rst`=1.
- **Reset dominance:** a handshake in the same cycle as `rst`=1 is dropped.
- **Latency:** accept on edge N; bit 0 of the transfer is on `so` after edge N and bit WIDTH-1 after edge N+WIDTH-1.
- **`done`:** high for the cycle after edge N+WIDTH-1.
- **Throughput:** with GAP==0, one word per WIDTH cycles. With GAP>0, one word per WIDTH+GAP+1 cycles, counting the IDLE cycle.
- **`busy`:** 1 from the edge after accept until the edge that returns the FSM to IDLE.
- **Output registers:** all outputs are registered except `din_ready`, which is a combinational decode of the state and `bitcnt`.
- **Sampling:** `so` and `dir` change only on rising edges. The downstream register samples them on the following edge.

## Test plan
- **Reset values:** hold `rst` 2 cycles, then release → `so`=0, `dir`=0, `busy`=0, `done`=0, `din_ready`=1.
- **LSB-first word:** send 8'hB5 with `msb_first`=0, GAP=0 → `so` sequence 1,0,1,0,1,1,0,1, `dir`=0, `done` on the 8th bit, then `so`=0.
- **MSB-first word:** send 8'hB5 with `msb_first`=1 → `so` sequence 1,0,1,1,0,1,0,1, `dir`=1 for all 8 cycles.
- **Back-to-back:** send 8'hFF then 8'h00 back-to-back with GAP=0 → 8 ones immediately followed by 8 zeros, no idle bit, two `done` pulses 8 cycles apart, `din_ready` high in both last-bit cycles.
- **Gap insertion:** GAP=4, send 8'h81 then 8'h81 with `din_valid` held high → second word's first bit starts 13 cycles after the first word's first bit, `so`=0 during the 4 gap cycles, `din_ready`=0 for 12 consecutive cycles.
- **Reset mid-word:** assert `rst` after the 3rd bit of 8'hAA → no `done`, `busy`=0 and `so`=0 on the next cycle. The next word 8'h0F, sent LSB-first, then transmits correctly as 1,1,1,1,0,0,0,0.
